sha256_wrapper: RTL and testbench

- Single-block SHA-256 compression engine for the miner datapath.
- Takes a precomputed midstate (chaining value after the first header block) and the second 512-bit padded block.
- Runs the 64 compression rounds iteratively, one round per clock, and presents midstate + compressed state as the 256-bit hash.
- Free-running: it recaptures its inputs and recomputes continuously, with no start/done handshake.

---
 rtl/sha256_pkg.sv | 74 +++++++
 rtl/sha256_round.sv | 48 ++++
 rtl/sha256_wrapper.sv | 107 ++++++++++
 tb/tb_sha256_wrapper.sv | 132 +++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ============================================================================
// Module : sha256_pkg
// Brief  : SHA-256 types, round constants, IV and FIPS 180-4 helper functions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    localparam int ROUNDS = 64;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:255] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// ============================================================================
// Module : sha256_round
// Brief  : One combinational SHA-256 compression round.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    word_t w_t1;
    word_t w_t2;

    assign w_t1 = h_i + bsig1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    assign w_t2 = bsig0(a_i) + maj(a_i, b_i, c_i);

    assign a_o = w_t1 + w_t2;
    assign b_o = a_i;
    assign c_o = b_i;
    assign d_o = c_i;
    assign e_o = d_i + w_t1;
    assign f_o = e_i;
    assign g_o = f_i;
    assign h_o = g_i;

endmodule

`default_nettype wire

// File: rtl/sha256_wrapper.sv
// ============================================================================
// Module : sha256_wrapper
// Brief  : Free-running iterative SHA-256 second-block compressor (66-cycle period).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sha256_wrapper
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [0:255] midstate,
    input  logic [0:511] block2,
    output logic [0:255] sha256_1_hashed_value
);

    state_e       state_q;
    logic [5:0]   cnt_q;
    word_t        st_q   [0:7];
    word_t        hold_q [0:7];
    word_t        w_q    [0:15];
    logic [0:255] hash_q;

    word_t        st_d   [0:7];
    word_t        w_tail_d;

    // W[t+16] from the window holding W[t..t+15]
    assign w_tail_d = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    sha256_round u_round (
        .a_i (st_q[0]),
        .b_i (st_q[1]),
        .c_i (st_q[2]),
        .d_i (st_q[3]),
        .e_i (st_q[4]),
        .f_i (st_q[5]),
        .g_i (st_q[6]),
        .h_i (st_q[7]),
        .k_i (K[cnt_q]),
        .w_i (w_q[0]),
        .a_o (st_d[0]),
        .b_o (st_d[1]),
        .c_o (st_d[2]),
        .d_o (st_d[3]),
        .e_o (st_d[4]),
        .f_o (st_d[5]),
        .g_o (st_d[6]),
        .h_o (st_d[7])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= 6'd0;
            hash_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                st_q[i]   <= '0;
                hold_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    for (int i = 0; i < 8; i++) begin
                        st_q[i]   <= midstate[32*i +: 32];
                        hold_q[i] <= midstate[32*i +: 32];
                    end
                    for (int i = 0; i < 16; i++) begin
                        w_q[i] <= block2[32*i +: 32];
                    end
                    cnt_q   <= 6'd0;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    for (int i = 0; i < 8; i++) begin
                        st_q[i] <= st_d[i];
                    end
                    for (int i = 0; i < 15; i++) begin
                        w_q[i] <= w_q[i+1];
                    end
                    w_q[15] <= w_tail_d;
                    cnt_q   <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ROUNDS - 1)) begin
                        state_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        hash_q[32*i +: 32] <= hold_q[i] + st_q[i];
                    end
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign sha256_1_hashed_value = hash_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_wrapper.sv
// ============================================================================
// Module : tb_sha256_wrapper
// Brief  : Directed known-answer, latency and reset bench for sha256_wrapper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_wrapper;
    import sha256_pkg::*;

    localparam logic [0:511] c_ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [0:511] c_EMPTY_BLK = {32'h80000000, {15{32'h0}}};
    localparam logic [255:0] c_ABC_HASH  =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY_HASH =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:511] r_block2;
    logic [0:255] r_midstate;
    logic [0:255] w_hash;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cnt_bad;

    always #5 clk = ~clk;

    sha256_wrapper u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .midstate              (r_midstate),
        .block2                (r_block2),
        .sha256_1_hashed_value (w_hash)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst        = 1'b1;
        r_midstate = IV;
        r_block2   = c_ABC_BLK;
        repeat (3) @(posedge clk);
        #1;
        check("reset_zero", w_hash, '0);

        // Phase A: constant "abc" input, latency and hold
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        cnt_bad = 0;
        for (int n = 1; n <= 65; n++) begin
            step();
            if (w_hash !== '0) cnt_bad++;
        end
        check("zero_c1_c65", 256'(cnt_bad), '0);
        step();
        check("abc_c66", w_hash, c_ABC_HASH);
        cnt_bad = 0;
        for (int n = 67; n <= 131; n++) begin
            step();
            if (w_hash !== c_ABC_HASH) cnt_bad++;
        end
        check("abc_hold_c67_c131", 256'(cnt_bad), '0);
        step();
        check("abc_c132", w_hash, c_ABC_HASH);

        // Asynchronous clear between clock edges
        rst = 1'b1;
        #1;
        check("async_clear_a", w_hash, '0);

        // Phase B: block changes at cycle 20 of the first computation
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 20; n++) step();
        r_block2 = c_EMPTY_BLK;
        for (int n = 21; n <= 65; n++) step();
        check("midchange_c65_zero", w_hash, '0);
        step();
        check("midchange_abc_c66", w_hash, c_ABC_HASH);
        step();
        check("midchange_abc_c67", w_hash, c_ABC_HASH);
        for (int n = 68; n <= 131; n++) step();
        check("midchange_abc_c131", w_hash, c_ABC_HASH);
        step();
        check("empty_c132", w_hash, c_EMPTY_HASH);

        // Reset at cycle 40 of the next computation
        for (int n = 133; n <= 172; n++) step();
        check("empty_before_rst", w_hash, c_EMPTY_HASH);
        rst = 1'b1;
        #1;
        check("async_clear_b", w_hash, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_zero", w_hash, '0);

        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        cnt_bad = 0;
        for (int n = 1; n <= 65; n++) begin
            step();
            if (w_hash !== '0) cnt_bad++;
        end
        check("post_rst_zero_c1_c65", 256'(cnt_bad), '0);
        step();
        check("empty_post_rst_c66", w_hash, c_EMPTY_HASH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
